// File: rtl/mc_pipeline_controller.sv
// Three-stage (ID/EX/WB) micro-controller core with a single WB->EX bypass.
// One instruction per clock, no stalls; jump flag and read-back are registered.
module mc_pipeline_controller #(
    parameter int IW = 3,
    parameter int DW = 32,
    parameter int AW = 4
) (
    input  logic          mc_clk,
    input  logic          mc_rst_n,
    input  logic [IW-1:0] mc_inst,
    input  logic [AW-1:0] mc_src1,
    input  logic [AW-1:0] mc_src2,
    input  logic [AW-1:0] mc_dst,
    input  logic [DW-1:0] mc_data,
    output logic          mc_jump,
    output logic [DW-1:0] mc_read_output
);

    localparam int NREG = 1 << AW;

    localparam logic [IW-1:0] OP_MOV  = IW'(3'd0);
    localparam logic [IW-1:0] OP_ADD  = IW'(3'd1);
    localparam logic [IW-1:0] OP_SUB  = IW'(3'd2);
    localparam logic [IW-1:0] OP_MUL  = IW'(3'd3);
    localparam logic [IW-1:0] OP_CJE  = IW'(3'd4);
    localparam logic [IW-1:0] OP_LOAD = IW'(3'd5);
    localparam logic [IW-1:0] OP_READ = IW'(3'd6);
    localparam logic [IW-1:0] OP_NOP  = IW'(3'd7);

    logic [IW-1:0] id_inst_r;
    logic [AW-1:0] id_src1_r;
    logic [AW-1:0] id_src2_r;
    logic [AW-1:0] id_dst_r;
    logic [DW-1:0] id_data_r;

    logic          wb_we_r;
    logic [AW-1:0] wb_dst_r;
    logic [DW-1:0] wb_result_r;

    logic [DW-1:0] reg_file_r [NREG];

    logic          jump_r;
    logic [DW-1:0] read_r;

    logic [DW-1:0] op_a_s;
    logic [DW-1:0] op_b_s;
    logic [DW-1:0] ex_result_s;
    logic          ex_we_s;
    logic          ex_jump_s;
    logic          ex_read_s;

    // ID stage: capture the incoming instruction; reset turns it into a nop
    always_ff @(posedge mc_clk) begin
        if (!mc_rst_n) begin
            id_inst_r <= OP_NOP;
            id_src1_r <= '0;
            id_src2_r <= '0;
            id_dst_r  <= '0;
            id_data_r <= '0;
        end else begin
            id_inst_r <= mc_inst;
            id_src1_r <= mc_src1;
            id_src2_r <= mc_src2;
            id_dst_r  <= mc_dst;
            id_data_r <= mc_data;
        end
    end

    // EX operand fetch: the instruction one ahead is still in WB, so bypass it
    always_comb begin
        op_a_s = reg_file_r[id_src1_r];
        op_b_s = reg_file_r[id_src2_r];
        if (wb_we_r && (wb_dst_r == id_src1_r)) begin
            op_a_s = wb_result_r;
        end else begin
            op_a_s = reg_file_r[id_src1_r];
        end
        if (wb_we_r && (wb_dst_r == id_src2_r)) begin
            op_b_s = wb_result_r;
        end else begin
            op_b_s = reg_file_r[id_src2_r];
        end
    end

    // EX datapath: result, write-enable and side-effect strobes per opcode
    always_comb begin
        ex_result_s = '0;
        ex_we_s     = 1'b0;
        ex_jump_s   = 1'b0;
        ex_read_s   = 1'b0;
        case (id_inst_r)
            OP_MOV: begin
                ex_result_s = op_a_s;
                ex_we_s     = 1'b1;
            end
            OP_ADD: begin
                ex_result_s = op_a_s + op_b_s;
                ex_we_s     = 1'b1;
            end
            OP_SUB: begin
                ex_result_s = op_a_s - op_b_s;
                ex_we_s     = 1'b1;
            end
            OP_MUL: begin
                ex_result_s = op_a_s * op_b_s;
                ex_we_s     = 1'b1;
            end
            OP_CJE: begin
                ex_jump_s = (op_a_s == op_b_s);
            end
            OP_LOAD: begin
                ex_result_s = id_data_r;
                ex_we_s     = 1'b1;
            end
            OP_READ: begin
                ex_read_s = 1'b1;
            end
            default: begin
                ex_result_s = '0;
                ex_we_s     = 1'b0;
            end
        endcase
    end

    // WB registers and registered outputs; reset cancels any in-flight write
    always_ff @(posedge mc_clk) begin
        if (!mc_rst_n) begin
            wb_we_r     <= 1'b0;
            wb_dst_r    <= '0;
            wb_result_r <= '0;
            jump_r      <= 1'b0;
            read_r      <= '0;
        end else begin
            wb_we_r     <= ex_we_s;
            wb_dst_r    <= id_dst_r;
            wb_result_r <= ex_result_s;
            jump_r      <= ex_jump_s;
            if (ex_read_s) begin
                read_r <= op_a_s;
            end else begin
                read_r <= read_r;
            end
        end
    end

    // Register file write from WB
    always_ff @(posedge mc_clk) begin
        if (!mc_rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                reg_file_r[i] <= '0;
            end
        end else if (wb_we_r) begin
            reg_file_r[wb_dst_r] <= wb_result_r;
        end else begin
            reg_file_r[wb_dst_r] <= reg_file_r[wb_dst_r];
        end
    end

    assign mc_jump        = jump_r;
    assign mc_read_output = read_r;

endmodule

// File: tb/tb_mc_pipeline_controller.sv
// Bench for mc_pipeline_controller: directed hazard/boundary sequence plus random
// instructions checked against an architectural (sequential-execution) model.
module tb_mc_pipeline_controller;

    localparam logic [2:0] MOV = 3'd0, ADD = 3'd1, SUB = 3'd2, MUL = 3'd3,
                           CJE = 3'd4, LOAD = 3'd5, READ = 3'd6, NOP = 3'd7;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  inst = NOP;
    logic [3:0]  src1 = 4'd0, src2 = 4'd0, dst = 4'd0;
    logic [31:0] data = 32'd0;
    logic        jump;
    logic [31:0] rd_out;

    int checks = 0;
    int errors = 0;

    // Architectural state: forwarding makes the pipeline equal to in-order execution
    logic [31:0] m_regs [16];
    logic        exp_jump = 1'b0;
    logic [31:0] exp_read = 32'd0;

    mc_pipeline_controller dut (
        .mc_clk(clk), .mc_rst_n(rst_n), .mc_inst(inst), .mc_src1(src1),
        .mc_src2(src2), .mc_dst(dst), .mc_data(data),
        .mc_jump(jump), .mc_read_output(rd_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_regs[i] = 32'd0;
        exp_jump = 1'b0;
        exp_read = 32'd0;
    endtask

    // Issue one instruction; after its sampling edge, outputs reflect the previous one
    task automatic step(input logic [2:0] op, input logic [3:0] s1, input logic [3:0] s2,
                        input logic [3:0] d, input logic [31:0] dat);
        logic [31:0] a, b;
        @(negedge clk);
        rst_n = 1'b1;
        inst = op; src1 = s1; src2 = s2; dst = d; data = dat;
        @(posedge clk);
        #1;
        chk("jump", {31'd0, jump}, {31'd0, exp_jump});
        chk("read", rd_out, exp_read);
        a = m_regs[s1];
        b = m_regs[s2];
        exp_jump = (op == CJE) && (a == b);
        case (op)
            MOV:  m_regs[d] = a;
            ADD:  m_regs[d] = a + b;
            SUB:  m_regs[d] = a - b;
            MUL:  m_regs[d] = 32'((64'(a) * 64'(b)) % 64'h1_0000_0000);
            LOAD: m_regs[d] = dat;
            READ: exp_read = a;
            default: ;
        endcase
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        inst = NOP;
        @(posedge clk);
        #1;
        chk("rst_jump", {31'd0, jump}, 32'd0);
        chk("rst_read", rd_out, 32'd0);
        model_reset();
    endtask

    task automatic nop();
        step(NOP, 4'd0, 4'd0, 4'd0, 32'd0);
    endtask

    task automatic read_expect(input string tag, input logic [3:0] r, input logic [31:0] v);
        step(READ, r, 4'd0, 4'd0, 32'd0);
        nop();
        chk(tag, rd_out, v);
    endtask

    initial begin
        model_reset();
        do_reset();
        do_reset();

        // back-to-back hazards
        step(LOAD, 4'd0, 4'd0, 4'd0, 32'd51);
        step(LOAD, 4'd0, 4'd0, 4'd1, 32'd2);
        step(ADD,  4'd0, 4'd1, 4'd2, 32'd0);
        step(SUB,  4'd0, 4'd1, 4'd3, 32'd0);
        step(MUL,  4'd0, 4'd1, 4'd4, 32'd0);
        step(MOV,  4'd1, 4'd0, 4'd5, 32'd0);
        step(MOV,  4'd1, 4'd0, 4'd6, 32'd0);
        nop();
        nop();
        read_expect("r0", 4'd0, 32'd51);
        read_expect("r1", 4'd1, 32'd2);
        read_expect("r2", 4'd2, 32'd53);
        read_expect("r3", 4'd3, 32'd49);
        read_expect("r4", 4'd4, 32'd102);
        read_expect("r5", 4'd5, 32'd2);
        read_expect("r6", 4'd6, 32'd2);

        // compare-jump
        step(CJE, 4'd0, 4'd5, 4'd0, 32'd0);
        nop();
        chk("cje_ne", {31'd0, jump}, 32'd0);
        step(CJE, 4'd5, 4'd6, 4'd0, 32'd0);
        nop();
        chk("cje_eq", {31'd0, jump}, 32'd1);
        nop();
        chk("cje_one_cycle", {31'd0, jump}, 32'd0);

        // read hold
        step(READ, 4'd1, 4'd0, 4'd0, 32'd0);
        nop();
        step(ADD, 4'd2, 4'd3, 4'd9, 32'd0);
        nop();
        step(ADD, 4'd9, 4'd9, 4'd10, 32'd0);
        nop();
        chk("read_hold", rd_out, 32'd2);

        // wrap-around
        step(LOAD, 4'd0, 4'd0, 4'd0, 32'd0);
        step(LOAD, 4'd0, 4'd0, 4'd1, 32'd1);
        step(SUB,  4'd0, 4'd1, 4'd2, 32'd0);
        step(LOAD, 4'd0, 4'd0, 4'd3, 32'h0001_0000);
        step(MUL,  4'd3, 4'd3, 4'd4, 32'd0);
        read_expect("sub_wrap", 4'd2, 32'hFFFF_FFFF);
        read_expect("mul_wrap", 4'd4, 32'd0);

        // same-register hazard
        step(LOAD, 4'd0, 4'd0, 4'd8, 32'd3);
        step(ADD,  4'd8, 4'd8, 4'd8, 32'd0);
        step(ADD,  4'd8, 4'd8, 4'd8, 32'd0);
        read_expect("r8_same_reg", 4'd8, 32'd12);

        // reset mid-stream cancels the in-flight load
        step(LOAD, 4'd0, 4'd0, 4'd7, 32'd5);
        do_reset();
        read_expect("r7_after_rst", 4'd7, 32'd0);
        read_expect("r8_after_rst", 4'd8, 32'd0);

        // random instructions against the model
        for (int i = 0; i < 400; i++) begin
            logic [2:0]  op;
            logic [31:0] dv;
            op = 3'($urandom_range(0, 7));
            dv = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 3)) : 32'($urandom);
            step(op, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)), dv);
            if (i == 200) do_reset();
        end
        for (int r = 0; r < 16; r++) begin
            step(READ, 4'(r), 4'd0, 4'd0, 32'd0);
        end
        nop();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
